// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load kinds, store kinds, write-back selects.
package mem_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned LD_KIND_W  = 3;
  localparam int unsigned ST_KIND_W  = 2;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned REG_ADDR_W = 5;

  // Load kinds; 101-111 decode as LW.
  localparam logic [LD_KIND_W-1:0] LD_W  = 3'b000;
  localparam logic [LD_KIND_W-1:0] LD_H  = 3'b001;
  localparam logic [LD_KIND_W-1:0] LD_HU = 3'b010;
  localparam logic [LD_KIND_W-1:0] LD_B  = 3'b011;
  localparam logic [LD_KIND_W-1:0] LD_BU = 3'b100;

  // Store kinds; 11 is reserved and performs no write.
  localparam logic [ST_KIND_W-1:0] ST_W = 2'b00;
  localparam logic [ST_KIND_W-1:0] ST_H = 2'b01;
  localparam logic [ST_KIND_W-1:0] ST_B = 2'b10;

  // Write-back source selects; anything other than WB_MEM returns the ALU value.
  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;

endpackage

// File: rtl/load_extract.sv
// Load data extraction: picks the addressed halfword/byte from a big-endian
// word, sign- or zero-extends it, and flags misaligned accesses (data forced to 0).
// Ports:
//   word_i       memory word at the addressed index
//   off_i        byte offset within the word (0 = bits 31:24)
//   kind_i       load kind (LD_*)
//   ext_data_o   extended load value, 0 when misaligned
//   misaligned_o access violates its natural alignment
module load_extract
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]      word_i,
  input  logic [1:0]           off_i,
  input  logic [LD_KIND_W-1:0] kind_i,
  output logic [XLEN-1:0]      ext_data_o,
  output logic                 misaligned_o
);

  logic [15:0]     half;
  logic [7:0]      byte_sel;
  logic [XLEN-1:0] value;
  logic            mis;

  // Big-endian lane selection.
  always_comb begin
    half     = off_i[1] ? word_i[15:0] : word_i[31:16];
    byte_sel = word_i[31:24];
    case (off_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Extension by kind; unknown kinds fall back to a word load.
  always_comb begin
    value = word_i;
    mis   = 1'b0;
    case (kind_i)
      LD_H: begin
        value = {{16{half[15]}}, half};
        mis   = off_i[0];
      end
      LD_HU: begin
        value = {16'h0000, half};
        mis   = off_i[0];
      end
      LD_B:    value = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   value = {24'h000000, byte_sel};
      default: begin
        value = word_i;
        mis   = |off_i;
      end
    endcase
  end

  assign ext_data_o   = mis ? '0 : value;
  assign misaligned_o = mis;

endmodule

// File: rtl/stage_mem.sv
// MEM stage: data memory with byte-lane stores and extended loads, branch
// resolution, MEM/WB latch and the write-back mux that also feeds EX forwarding.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   inAlu .. inflag*            EX/MEM latch outputs (address, data, control)
//   outPCSrc, outBranchTarget   combinational branch decision and target
//   outRegWriteWB, outWriteRegWB MEM/WB RegWrite and destination register
//   outMuxWb                    combinational write-back value from the latch
//   outMisaligned               sticky misaligned-access flag
module stage_mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 8,
  parameter              INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       inAlu,
  input  logic                  inZeroAlu,
  input  logic [XLEN-1:0]       inDataRt,
  input  logic [XLEN-1:0]       inAddEx,
  input  logic [REG_ADDR_W-1:0] inMuxRtRd,
  input  logic [WB_SEL_W-1:0]   inMemtoReg,
  input  logic                  inRegWrite,
  input  logic                  inMemRead,
  input  logic                  inMemWrite,
  input  logic                  inBranch,
  input  logic [LD_KIND_W-1:0]  inflagLoadWordDividerMEM,
  input  logic [ST_KIND_W-1:0]  inflagStoreWordDividerMEM,
  output logic                  outPCSrc,
  output logic [XLEN-1:0]       outBranchTarget,
  output logic                  outRegWriteWB,
  output logic [REG_ADDR_W-1:0] outWriteRegWB,
  output logic [XLEN-1:0]       outMuxWb,
  output logic                  outMisaligned
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  // No preload path in this synthesizable model; the parameter is kept for
  // interface compatibility with the original stage.
  logic unused_init_file;
  assign unused_init_file = ^INIT_FILE;

  logic [XLEN-1:0]    mem_q [DEPTH];
  logic [DEPTH_W-1:0] widx;
  logic [XLEN-1:0]    rd_word;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic            st_mis;
  logic            st_we;

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;

  logic [XLEN-1:0]       alu_q,      alu_d;
  logic [XLEN-1:0]       ld_q,       ld_d;
  logic [WB_SEL_W-1:0]   memtoreg_q, memtoreg_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] wreg_q,     wreg_d;
  logic                  mis_q,      mis_d;

  // Upper address bits wrap onto the array.
  assign widx    = inAlu[DEPTH_W+1:2];
  assign rd_word = mem_q[widx];

  // Branch resolves with no latency; flushing is decided outside this stage.
  assign outPCSrc        = inBranch & inZeroAlu;
  assign outBranchTarget = inAddEx;

  // Store lane enables; st_be[3] is byte offset 0 (bits 31:24).
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = inDataRt;
    st_mis   = 1'b0;
    case (inflagStoreWordDividerMEM)
      ST_W: begin
        st_be  = 4'b1111;
        st_mis = |inAlu[1:0];
      end
      ST_H: begin
        st_be    = inAlu[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{inDataRt[15:0]}};
        st_mis   = inAlu[0];
      end
      ST_B: begin
        st_be    = 4'b1000 >> inAlu[1:0];
        st_wdata = {4{inDataRt[7:0]}};
      end
      default: st_be = 4'b0000;
    endcase
  end

  // Reset and misalignment both suppress the write.
  assign st_we = inMemWrite & ~st_mis & ~reset;

  // Data memory; contents survive reset. Reads are asynchronous, so a same-cycle
  // load sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[widx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  load_extract u_load_extract (
    .word_i       (rd_word),
    .off_i        (inAlu[1:0]),
    .kind_i       (inflagLoadWordDividerMEM),
    .ext_data_o   (ld_data),
    .misaligned_o (ld_mis)
  );

  assign alu_d      = inAlu;
  assign ld_d       = ld_data;
  assign memtoreg_d = inMemtoReg;
  assign regwrite_d = inRegWrite;
  assign wreg_d     = inMuxRtRd;
  assign mis_d      = mis_q | (inMemRead & ld_mis) | (inMemWrite & st_mis);

  // MEM/WB latch; loads every cycle, no stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q      <= '0;
      ld_q       <= '0;
      memtoreg_q <= WB_ALU;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      mis_q      <= 1'b0;
    end else begin
      alu_q      <= alu_d;
      ld_q       <= ld_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      mis_q      <= mis_d;
    end
  end

  assign outRegWriteWB = regwrite_q;
  assign outWriteRegWB = wreg_q;
  assign outMisaligned = mis_q;
  assign outMuxWb      = (memtoreg_q == WB_MEM) ? ld_q : alu_q;

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inAlu;
  logic        inZeroAlu;
  logic [31:0] inDataRt;
  logic [31:0] inAddEx;
  logic [4:0]  inMuxRtRd;
  logic [1:0]  inMemtoReg;
  logic        inRegWrite;
  logic        inMemRead;
  logic        inMemWrite;
  logic        inBranch;
  logic [2:0]  inLd;
  logic [1:0]  inSt;
  logic        outPCSrc;
  logic [31:0] outBranchTarget;
  logic        outRegWriteWB;
  logic [4:0]  outWriteRegWB;
  logic [31:0] outMuxWb;
  logic        outMisaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  stage_mem #(.DEPTH_W(8), .INIT_FILE("")) dut (
    .clk                       (clk),
    .reset                     (reset),
    .inAlu                     (inAlu),
    .inZeroAlu                 (inZeroAlu),
    .inDataRt                  (inDataRt),
    .inAddEx                   (inAddEx),
    .inMuxRtRd                 (inMuxRtRd),
    .inMemtoReg                (inMemtoReg),
    .inRegWrite                (inRegWrite),
    .inMemRead                 (inMemRead),
    .inMemWrite                (inMemWrite),
    .inBranch                  (inBranch),
    .inflagLoadWordDividerMEM  (inLd),
    .inflagStoreWordDividerMEM (inSt),
    .outPCSrc                  (outPCSrc),
    .outBranchTarget           (outBranchTarget),
    .outRegWriteWB             (outRegWriteWB),
    .outWriteRegWB             (outWriteRegWB),
    .outMuxWb                  (outMuxWb),
    .outMisaligned             (outMisaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inAlu = 32'h0; inZeroAlu = 1'b0; inDataRt = 32'h0; inAddEx = 32'h0;
    inMuxRtRd = 5'd0; inMemtoReg = 2'b00; inRegWrite = 1'b0;
    inMemRead = 1'b0; inMemWrite = 1'b0; inBranch = 1'b0;
    inLd = 3'b000; inSt = 2'b11;
  endtask

  // Store: one cycle with MemWrite, then inputs return to idle.
  task automatic st(input logic [31:0] addr, input logic [1:0] kind, input logic [31:0] data);
    idle();
    inAlu = addr; inSt = kind; inDataRt = data; inMemWrite = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  // Load: expected value pushed on issue, popped and compared after the capture edge.
  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] kind,
                    input logic [31:0] exp);
    logic [31:0] e;
    idle();
    inAlu = addr; inLd = kind; inMemRead = 1'b1; inMemtoReg = 2'b01;
    inRegWrite = 1'b1; inMuxRtRd = 5'd9;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, outMuxWb, e);
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 32'(outRegWriteWB), 32'd0);
    chk("rst_wreg",     32'(outWriteRegWB), 32'd0);
    chk("rst_muxwb",    outMuxWb, 32'd0);
    chk("rst_mis",      32'(outMisaligned), 32'd0);
    reset = 1'b0;

    // Word store then word load, with latch sideband.
    st(32'h10, 2'b00, 32'h11223344);
    ld("lw_10", 32'h10, 3'b000, 32'h11223344);
    chk("lw_regwrite", 32'(outRegWriteWB), 32'd1);
    chk("lw_wreg",     32'(outWriteRegWB), 32'd9);

    // Byte store and byte loads.
    st(32'h11, 2'b10, 32'hFFFFFFAB);
    ld("lw_after_sb", 32'h10, 3'b000, 32'h11AB3344);
    ld("lb_11",       32'h11, 3'b011, 32'hFFFFFFAB);
    ld("lbu_11",      32'h11, 3'b100, 32'h000000AB);
    ld("lbu_13",      32'h13, 3'b100, 32'h00000044);

    // Halfword store and halfword loads.
    st(32'h12, 2'b01, 32'h12348001);
    ld("lh_12",       32'h12, 3'b001, 32'hFFFF8001);
    ld("lhu_12",      32'h12, 3'b010, 32'h00008001);
    ld("lw_after_sh", 32'h10, 3'b000, 32'h11AB8001);
    ld("lh_10",       32'h10, 3'b001, 32'h000011AB);
    ld("lw_kind7",    32'h10, 3'b111, 32'h11AB8001);

    // Reserved store kind writes nothing.
    st(32'h10, 2'b11, 32'hFFFFFFFF);
    ld("lw_after_rsv", 32'h10, 3'b000, 32'h11AB8001);

    // Address wrap: 0x410 aliases word index 4.
    st(32'h410, 2'b00, 32'hCAFE0410);
    ld("lw_wrap", 32'h10, 3'b000, 32'hCAFE0410);

    // ALU write-back path for MemtoReg 00 and 10.
    idle();
    inAlu = 32'h12345678; inMemtoReg = 2'b00; inRegWrite = 1'b1; inMuxRtRd = 5'd3;
    @(posedge clk); #1;
    chk("wb_alu_00", outMuxWb, 32'h12345678);
    idle();
    inAlu = 32'h0000ABCD; inMemtoReg = 2'b10; inRegWrite = 1'b1;
    @(posedge clk); #1;
    chk("wb_alu_10", outMuxWb, 32'h0000ABCD);

    // Read and write together: load returns the old contents.
    st(32'h18, 2'b00, 32'h01020304);
    idle();
    inAlu = 32'h18; inSt = 2'b00; inDataRt = 32'h55667788; inMemWrite = 1'b1;
    inMemRead = 1'b1; inLd = 3'b000; inMemtoReg = 2'b01; inRegWrite = 1'b1;
    @(posedge clk); #1;
    chk("rw_old", outMuxWb, 32'h01020304);
    ld("rw_new", 32'h18, 3'b000, 32'h55667788);
    chk("mis_clean", 32'(outMisaligned), 32'd0);

    // Misaligned store is suppressed and sets the sticky flag.
    st(32'h14, 2'b00, 32'hA5A5A5A5);
    st(32'h16, 2'b00, 32'hDEADDEAD);
    chk("mis_set_st", 32'(outMisaligned), 32'd1);
    ld("lw_after_mis", 32'h14, 3'b000, 32'hA5A5A5A5);
    chk("mis_sticky", 32'(outMisaligned), 32'd1);

    // Misaligned loads return 0 but still write back.
    ld("lw_mis", 32'h12, 3'b000, 32'h00000000);
    chk("lw_mis_regwrite", 32'(outRegWriteWB), 32'd1);
    ld("lh_mis", 32'h11, 3'b001, 32'h00000000);

    // Branch resolution is combinational.
    idle();
    inBranch = 1'b1; inZeroAlu = 1'b1; inAddEx = 32'h40;
    #1;
    chk("pcsrc_taken", 32'(outPCSrc), 32'd1);
    chk("btarget",     outBranchTarget, 32'h40);
    inZeroAlu = 1'b0;
    #1;
    chk("pcsrc_nz", 32'(outPCSrc), 32'd0);
    inBranch = 1'b0; inZeroAlu = 1'b1;
    #1;
    chk("pcsrc_nobr", 32'(outPCSrc), 32'd0);
    @(posedge clk); #1;

    // Reset beats a concurrent store and clears the sticky flag.
    st(32'h20, 2'b00, 32'hCAFEF00D);
    idle();
    reset = 1'b1;
    inAlu = 32'h20; inSt = 2'b00; inDataRt = 32'hDEADBEEF; inMemWrite = 1'b1;
    inRegWrite = 1'b1; inMemtoReg = 2'b00; inMuxRtRd = 5'd7;
    @(posedge clk); #1;
    chk("rst2_regwrite", 32'(outRegWriteWB), 32'd0);
    chk("rst2_muxwb",    outMuxWb, 32'd0);
    chk("rst2_mis",      32'(outMisaligned), 32'd0);
    reset = 1'b0;
    ld("lw_after_rst", 32'h20, 3'b000, 32'hCAFEF00D);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
